// File: rtl/loop_filter_ctrl.sv
// loop_filter_ctrl: bang-bang PD acquisition/lock sequencer feeding loop filter up/dn; define LF_CTRL_DBG_EN for win_net/win_done debug ports
module loop_filter_ctrl #(
  parameter int WIN_LOG2    = 4,
  parameter int BAL_THR     = 2,
  parameter int ACQ_WINS    = 4,
  parameter int LOCK_WINS   = 8,
  parameter int UNLOCK_WINS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       pd_up,
  input  logic       pd_dn,
  output logic       lf_up,
  output logic       lf_dn,
  output logic       locked,
  output logic [1:0] state
`ifdef LF_CTRL_DBG_EN
  ,
  output logic signed [WIN_LOG2+1:0] win_net,
  output logic                       win_done
`endif
);
  localparam int AW = WIN_LOG2 + 2;
  localparam int CW = $clog2(ACQ_WINS + LOCK_WINS + UNLOCK_WINS + 1);
  localparam logic signed [AW-1:0] THR = AW'(BAL_THR);
  typedef enum logic [1:0] {IDLE, ACQ, TRACK, LOCKED} st_t;
  st_t st, nxt;
  logic [WIN_LOG2-1:0] win_cnt;
  logic signed [AW-1:0] acc, samp, net;
  logic [CW-1:0] bal_cnt, unl_cnt;
  logic last, bal, clr, up_d, dn_d;
  assign samp = {{(AW-1){pd_dn & ~pd_up}}, pd_up ^ pd_dn};
  assign net = acc + samp;
  assign last = &win_cnt;
  assign bal = (net <= THR) && (net >= -THR);
  assign clr = (nxt != st) || (nxt == IDLE);
  assign locked = st == LOCKED;
  assign state = st;
  // next state and next lf command; pass-through only while staying in ACQ
  always_comb begin
    nxt = st;
    up_d = 1'b0;
    dn_d = 1'b0;
    if (!en) nxt = IDLE;
    else if (st == IDLE) nxt = ACQ;
    else if (last && st == ACQ && bal && bal_cnt == CW'(ACQ_WINS - 1)) nxt = TRACK;
    else if (last && st == TRACK && bal && bal_cnt == CW'(LOCK_WINS - 1)) nxt = LOCKED;
    else if (last && st == LOCKED && !bal && unl_cnt == CW'(UNLOCK_WINS - 1)) nxt = ACQ;
    if (en && st == ACQ && nxt == ACQ) begin
      up_d = pd_up & ~pd_dn;
      dn_d = pd_dn & ~pd_up;
    end else if (en && (st == TRACK || st == LOCKED) && last) begin
      up_d = net > THR;
      dn_d = net < -THR;
    end
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) st <= IDLE;
    else st <= nxt;
  // window accumulation, consecutive-window counters and registered commands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lf_up <= 1'b0;
      lf_dn <= 1'b0;
      win_cnt <= '0;
      acc <= '0;
      bal_cnt <= '0;
      unl_cnt <= '0;
    end else begin
      lf_up <= up_d;
      lf_dn <= dn_d;
      if (clr) begin
        win_cnt <= '0;
        acc <= '0;
        bal_cnt <= '0;
        unl_cnt <= '0;
      end else if (last) begin
        win_cnt <= '0;
        acc <= '0;
        bal_cnt <= bal ? bal_cnt + 1'b1 : '0;
        unl_cnt <= bal ? '0 : unl_cnt + 1'b1;
      end else begin
        win_cnt <= win_cnt + 1'b1;
        acc <= net;
      end
    end
  end
`ifdef LF_CTRL_DBG_EN
  // capture net of each completed window and flag it for one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_net <= '0;
      win_done <= 1'b0;
    end else begin
      win_done <= en && st != IDLE && last;
      if (en && st != IDLE && last) win_net <= net;
    end
  end
`endif
endmodule

// File: doc/loop_filter_ctrl.md
Name: loop_filter_ctrl

Overview:
Acquisition/lock sequencer between the bang-bang phase detector and the loop filter's up/dn command inputs.
- ACQ: passes raw detector pulses straight through for fast pull-in.
- TRACK/LOCKED: decimates pulses into at most one command per window to cut dither.
- Detects lock from consecutive balanced windows and reverts to ACQ on loss of lock.

Parameters:
WIN_LOG2, 4, log2 of window length in cycles (WIN = 16)
BAL_THR, 2, |net| <= BAL_THR counts as a balanced window
ACQ_WINS, 4, consecutive balanced windows needed for ACQ -> TRACK
LOCK_WINS, 8, consecutive balanced windows needed for TRACK -> LOCKED
UNLOCK_WINS, 3, consecutive unbalanced windows needed for LOCKED -> ACQ

Ports:
clk  in  1  single clock
rst  in  1  asynchronous, active-high reset
en  in  1  controller enable; low forces IDLE
pd_up  in  1  raw phase-detector up
pd_dn  in  1  raw phase-detector down
lf_up  out  1  up command to loop filter
lf_dn  out  1  down command to loop filter
locked  out  1  high only in LOCKED
state  out  2  IDLE=0, ACQ=1, TRACK=2, LOCKED=3

Behaviour:
- Reset (async): state=IDLE; lf_up=lf_dn=locked=0; win_cnt, acc and both window counters cleared.
- Sample value: pd_up&~pd_dn = +1, pd_dn&~pd_up = -1, 00/11 = 0.
- acc: signed, WIN_LOG2+2 bits; no saturation is needed (|net| <= WIN).
- win_cnt: 0..WIN-1. Window end is the cycle with win_cnt==WIN-1.
- Net at window end: net = acc + current sample. Decisions take effect on that clock edge; acc and win_cnt restart at 0.
- State entry: every state change clears win_cnt, acc and both consecutive-window counters.
- en=0 in any state: IDLE on the next edge, outputs 0, counters cleared; this overrides all other transitions.
- IDLE: lf_up/lf_dn = 0. en=1 -> ACQ on the next edge.
- ACQ:
  - Registered pass-through, 1-cycle latency: lf_up <= pd_up&~pd_dn; lf_dn <= pd_dn&~pd_up.
  - At window end: balanced -> bal_cnt+1, else bal_cnt=0.
  - bal_cnt reaching ACQ_WINS -> TRACK on that edge. lf outputs are 0 in the first TRACK cycle.
- TRACK:
  - lf outputs are 0 except at window end, where net > BAL_THR gives one-cycle lf_up, net < -BAL_THR gives one-cycle lf_dn, otherwise no pulse. The pulse appears in the cycle after the window-end cycle.
  - Balanced window: bal_cnt+1; unbalanced: bal_cnt=0.
  - bal_cnt==LOCK_WINS -> LOCKED; locked=1 from the first LOCKED cycle.
- LOCKED:
  - Output decimation identical to TRACK.
  - Unbalanced window: unl_cnt+1; balanced: unl_cnt=0.
  - unl_cnt==UNLOCK_WINS -> ACQ, locked=0.
  - The final window's decimated pulse is still emitted in the first ACQ cycle.
- lf_up and lf_dn are never both high.
- Reset mid-window: immediate clear. No partial-window decision is ever made.

Optional Feature:
LF_CTRL_DBG_EN:
- When defined, adds output win_net [WIN_LOG2+1:0] (signed net of the last completed window, registered at window end, reset 0) and output win_done (1-cycle pulse in the cycle after each window end, any non-IDLE state).
- When undefined, both ports and their registers are absent; all other behaviour is identical.

Test Plan:
1. rst=1 then release with en=0, pd_up=1 -> state=0, lf_up=lf_dn=locked=0 for 50 cycles.
2. en=1 -> state=1 next cycle. pd_up pulse at cycle t -> lf_up high at t+1 only. pd_up=pd_dn=1 -> lf_up=lf_dn=0.
3. In ACQ, alternate pd_up/pd_dn every cycle (net 0) -> state=2 exactly 64 cycles after ACQ entry.
4. In TRACK:
   - window with 10 up, 2 dn (net +8) -> exactly one lf_up pulse, the cycle after window end;
   - window with 3 up, 1 dn (net +2) -> no pulse, counted balanced;
   - net -5 -> one lf_dn pulse.
5. 8 balanced TRACK windows -> state=3, locked=1. Then hold pd_up=1 -> one lf_up per window; after the 3rd window state=1, locked=0. A balanced window between unbalanced ones resets unl_cnt and delays unlock.
6. Mid-window in LOCKED:
   - drop en -> IDLE next cycle, locked=0, outputs 0; re-enable -> full 4-window acquisition from zero counts;
   - repeat with rst pulse mid-window -> same result.
   - With LF_CTRL_DBG_EN: win_net=+8 after the scenario-4 window.
